player_link_tx: RTL and testbench

// - Scheduler that shares one byte-wide UART TX channel among all local player-state fields sent to the peer board.
// - On each frame_tick it snapshots char_x/y, hp, aggro, class, flip_h, game_start and boss_hp, then serialises one framed, checksummed packet.
// - Sits between the top-level game outputs and the UART transmitter; the peer's receiver rebuilds the player_2_* signals.

---
 rtl/link_pkg.sv | 49 ++++
 rtl/player_link_tx.sv | 119 +++++++++++
 tb/tb_player_link_tx.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the player-state link: framing constants, FSM states, packet byte mux.
package link_pkg;

    localparam logic [7:0]  HEADER  = 8'hA5;
    localparam int unsigned PKT_LEN = 9;
    localparam int unsigned OVR_W   = 8;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } link_state_t;

    typedef logic [IDX_W-1:0] byte_idx_t;

    // Snapshot of every local field carried by one packet
    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [3:0]  hp;
        logic [3:0]  aggro;
        logic [1:0]  cls;
        logic        flip_h;
        logic        game_start;
        logic [6:0]  boss_hp;
    } link_fields_t;

    // Byte at position idx of the packet; csum is used only for the trailing checksum byte
    function automatic logic [7:0] pkt_byte(input link_fields_t f, input byte_idx_t idx,
                                            input logic [7:0] csum);
        logic [7:0] b;
        case (idx)
            4'd0:    b = HEADER;
            4'd1:    b = {4'h0, f.x[11:8]};
            4'd2:    b = f.x[7:0];
            4'd3:    b = {4'h0, f.y[11:8]};
            4'd4:    b = f.y[7:0];
            4'd5:    b = {f.hp, f.aggro};
            4'd6:    b = {4'h0, f.game_start, f.flip_h, f.cls};
            4'd7:    b = {1'b0, f.boss_hp};
            4'd8:    b = csum;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/player_link_tx.sv
// Packet scheduler: snapshots local player state on frame_tick and serialises a 9-byte framed packet to the UART.
module player_link_tx
    import link_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             link_en,
    input  logic             frame_tick,
    input  logic [11:0]      char_x,
    input  logic [11:0]      char_y,
    input  logic [3:0]       current_health,
    input  logic [3:0]       char_aggro,
    input  logic [1:0]       char_class,
    input  logic             flip_h,
    input  logic             game_start,
    input  logic [6:0]       boss_hp,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    output logic             busy,
    output logic             frame_sent,
    output logic [OVR_W-1:0] overrun_cnt
);

    link_state_t  state;
    link_fields_t shadow;
    byte_idx_t    idx;
    logic [7:0]   checksum;
    logic         pending;

    byte_idx_t    idx_nxt;
    logic [7:0]   csum_nxt;
    logic [7:0]   byte_nxt;
    logic         last_byte;

    // Next byte to present after a handshake; checksum covers bytes 1..7 only
    assign idx_nxt   = byte_idx_t'(idx + 1'b1);
    assign csum_nxt  = (idx != '0) ? (checksum ^ tx_data) : checksum;
    assign byte_nxt  = pkt_byte(shadow, idx_nxt, csum_nxt);
    assign last_byte = (idx == byte_idx_t'(PKT_LEN - 1));

    // Packet FSM with registered UART handshake, pending-tick slot and saturating overrun counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            idx         <= '0;
            checksum    <= '0;
            pending     <= 1'b0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_sent  <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            frame_sent <= 1'b0;

            // Ticks while a packet is in flight: one is queued, further ones are counted as dropped
            if (!link_en) begin
                pending <= 1'b0;
            end else if (frame_tick && (state == LOAD || state == SEND)) begin
                if (!pending) begin
                    pending <= 1'b1;
                end else if (overrun_cnt != '1) begin
                    overrun_cnt <= overrun_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (link_en && (pending || frame_tick)) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        // A tick arriving together with a queued one stays queued
                        pending <= pending & frame_tick;
                    end
                end
                LOAD: begin
                    shadow   <= '{x: char_x, y: char_y, hp: current_health, aggro: char_aggro,
                                  cls: char_class, flip_h: flip_h, game_start: game_start,
                                  boss_hp: boss_hp};
                    idx      <= '0;
                    checksum <= '0;
                    tx_data  <= HEADER;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        if (last_byte) begin
                            tx_valid   <= 1'b0;
                            frame_sent <= 1'b1;
                            state      <= DONE;
                        end else begin
                            idx      <= idx_nxt;
                            checksum <= csum_nxt;
                            tx_data  <= byte_nxt;
                        end
                    end
                end
                DONE: begin
                    // Consume the queued tick; a tick arriving now takes the freed slot
                    pending <= frame_tick & link_en;
                    if (pending && link_en) begin
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_link_tx.sv
// Directed bench for player_link_tx: packet content, stalls, queuing/overrun, link enable, async reset.
module tb_player_link_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_en;
    logic        frame_tick;
    logic [11:0] char_x;
    logic [11:0] char_y;
    logic [3:0]  current_health;
    logic [3:0]  char_aggro;
    logic [1:0]  char_class;
    logic        flip_h;
    logic        game_start;
    logic [6:0]  boss_hp;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        frame_sent;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] got   [9];
    logic [7:0] exp_a [9];
    logic [7:0] exp_b [9];

    player_link_tx dut (
        .clk            (clk),
        .rst            (rst),
        .link_en        (link_en),
        .frame_tick     (frame_tick),
        .char_x         (char_x),
        .char_y         (char_y),
        .current_health (current_health),
        .char_aggro     (char_aggro),
        .char_class     (char_class),
        .flip_h         (flip_h),
        .game_start     (game_start),
        .boss_hp        (boss_hp),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .busy           (busy),
        .frame_sent     (frame_sent),
        .overrun_cnt    (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_inputs_a();
        char_x = 12'hABC; char_y = 12'h123; current_health = 4'd5; char_aggro = 4'd3;
        char_class = 2'd2; flip_h = 1'b1; game_start = 1'b1; boss_hp = 7'd100;
    endtask

    task automatic set_inputs_b();
        char_x = 12'hFFF; char_y = 12'h000; current_health = 4'd0; char_aggro = 4'hF;
        char_class = 2'd1; flip_h = 1'b0; game_start = 1'b0; boss_hp = 7'h7F;
    endtask

    // Collects bytes first..8 starting at the current negedge; returns at the negedge after the last handshake
    task automatic recv(input int first, input bit rnd);
        int         n = first;
        int         cyc = 0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        while (n < 9 && cyc < 500) begin
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, prev_data);
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (tx_valid && tx_ready) begin
                got[n] = tx_data;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b1;
        checks++;
        if (n < 9) begin
            errors++;
            $display("FAIL recv_timeout: got %0d bytes, required 9", n);
        end else if (frame_sent !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_sent_pulse: frame_sent=%b tx_valid=%b, required 1 0", frame_sent, tx_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; link_en = 1'b1; frame_tick = 1'b0; tx_ready = 1'b1;
        set_inputs_a();
        @(negedge clk);
        checks++;
        if (tx_data !== 8'h00 || tx_valid !== 1'b0 || busy !== 1'b0 || frame_sent !== 1'b0 || overrun_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: data=%h valid=%b busy=%b fs=%b ovr=%0d, required all 0",
                     tx_data, tx_valid, busy, frame_sent, overrun_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        set_inputs_a();
        tx_ready = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_cycle: valid=%b busy=%b, required 0 1", tx_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL first_byte_latency: valid=%b data=%h, required 1 a5", tx_valid, tx_data);
        end
        recv(0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL basic_byte%0d: got %h, required %h", i, got[i], exp_a[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame_sent !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_after: busy=%b fs=%b, required 0 0", busy, frame_sent);
        end
    endtask

    task automatic test_stall();
        set_inputs_a();
        tx_ready = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        set_inputs_b();
        recv(0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL stall_byte%0d: got %h, required %h", i, got[i], exp_a[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        set_inputs_a();
        tx_ready = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (overrun_cnt !== 8'd1) begin
            errors++;
            $display("FAIL b2b_overrun: got %0d, required 1", overrun_cnt);
        end
        recv(0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL b2b_pkt1_byte%0d: got %h, required %h", i, got[i], exp_a[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reload: busy=%b valid=%b, required 1 0", busy, tx_valid);
        end
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL b2b_second_start: valid=%b data=%h, required 1 a5", tx_valid, tx_data);
        end
        recv(0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL b2b_pkt2_byte%0d: got %h, required %h", i, got[i], exp_a[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || overrun_cnt !== 8'd1) begin
            errors++;
            $display("FAIL b2b_end: busy=%b ovr=%0d, required 0 1", busy, overrun_cnt);
        end
    endtask

    task automatic test_saturate();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_inputs_a();
        tx_ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (overrun_cnt !== 8'd255 || busy !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL overrun_saturate: ovr=%0d busy=%b valid=%b data=%h, required 255 1 1 a5",
                     overrun_cnt, busy, tx_valid, tx_data);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_link_en();
        bit seen_valid = 1'b0;
        set_inputs_a();
        link_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            if (tx_valid || busy) seen_valid = 1'b1;
            @(negedge clk);
            if (tx_valid || busy) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid) begin
            errors++;
            $display("FAIL link_off_idle: activity seen=1, required 0");
        end
        link_en = 1'b1;
        tx_ready = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tx_ready = 1'b1;
            got[i] = tx_data;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        link_en = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        recv(4, 1'b0);
        frame_tick = 1'b0;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL link_drop_byte%0d: got %h, required %h", i, got[i], exp_a[i]);
            end
        end
        seen_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            frame_tick = k[0];
            @(negedge clk);
            if (tx_valid || busy) seen_valid = 1'b1;
        end
        frame_tick = 1'b0;
        checks++;
        if (seen_valid || overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL link_drop_no_more: activity=%b ovr=%0d, required 0 0", seen_valid, overrun_cnt);
        end
        link_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        set_inputs_a();
        tx_ready = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            tx_ready = 1'b1;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        checks++;
        if (tx_data !== 8'h53 || overrun_cnt !== 8'd1) begin
            errors++;
            $display("FAIL pre_rst_idx5: data=%h ovr=%0d, required 53 1", tx_data, overrun_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_rst: valid=%b busy=%b ovr=%0d, required 0 0 0", tx_valid, busy, overrun_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        set_inputs_b();
        tx_ready = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        recv(0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL fresh_byte%0d: got %h, required %h", i, got[i], exp_b[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fresh_no_pending: busy=%b, required 0", busy);
        end
    endtask

    initial begin
        exp_a = '{8'hA5, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h53, 8'h0E, 8'h64, 8'hAD};
        exp_b = '{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h0F, 8'h01, 8'h7F, 8'h81};
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_saturate();
        test_link_en();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
